// File: rtl/tag_ram_sched.sv
// tag_ram_sched: tag-RAM access scheduler.
// Sweeps every set invalid after reset/flush, then arbitrates one RAM
// operation per cycle: refill > invalidate/touch > lookup.
// Optional build macro TAG_SCHED_STARVE_GUARD_EN forces a lookup grant after
// four back-to-back write grants that each left a lookup waiting.
module tag_ram_sched #(
  parameter int ADDR_WIDTH = 7,
  parameter int TAG_WIDTH  = 21
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     flush_req,
  output logic                     init_done,
  input  logic                     lk_valid,
  output logic                     lk_ready,
  input  logic [ADDR_WIDTH-1:0]    lk_index,
  output logic                     lk_rvalid,
  input  logic                     rf_valid,
  output logic                     rf_ready,
  input  logic [ADDR_WIDTH-1:0]    rf_index,
  input  logic                     rf_way,
  input  logic [TAG_WIDTH-1:0]     rf_tag,
  input  logic                     iv_valid,
  output logic                     iv_ready,
  input  logic [ADDR_WIDTH-1:0]    iv_index,
  input  logic                     iv_way,
  input  logic                     iv_touch,
  output logic [ADDR_WIDTH-1:0]    ram_raddr,
  output logic [ADDR_WIDTH-1:0]    ram_waddr,
  output logic                     ram_re,
  output logic [1:0]               ram_we,
  output logic [2*TAG_WIDTH+2:0]   ram_din,
  output logic                     ram_refill,
  output logic                     ram_load_over,
  output logic                     ram_cache_reset
);

  localparam logic [ADDR_WIDTH-1:0] CNT_MAX = '1;

  typedef enum logic {SWEEP, RUN} state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] sweep_cnt;
  logic                  run;
  logic                  wr_last_vld;
  logic [ADDR_WIDTH-1:0] wr_last_idx;
  logic [ADDR_WIDTH-1:0] raddr_q;
  logic                  lk_hazard;
  logic                  guard_take;
  logic                  rf_gnt, iv_gnt, lk_gnt;

  assign run = (state == RUN);

  // A lookup may not read a set whose write was issued last cycle.
  assign lk_hazard = wr_last_vld && (wr_last_idx == lk_index);

  // Fixed-priority readies; flush wins over every requester.
  assign rf_ready = run & ~flush_req & ~guard_take;
  assign iv_ready = run & ~flush_req & ~guard_take & ~rf_valid;
  assign lk_ready = run & ~flush_req & ~lk_hazard &
                    (guard_take | (~rf_valid & ~iv_valid));

  assign rf_gnt = rf_valid & rf_ready;
  assign iv_gnt = iv_valid & iv_ready;
  assign lk_gnt = lk_valid & lk_ready;

`ifdef TAG_SCHED_STARVE_GUARD_EN
  logic [2:0] starve_cnt;

  assign guard_take = lk_valid & ~lk_hazard & (starve_cnt == 3'd4);

  // Count consecutive write grants that left a lookup waiting (saturates at 4).
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                            starve_cnt <= 3'd0;
    else if ((rf_gnt | iv_gnt) && lk_valid) starve_cnt <= (starve_cnt == 3'd4) ? 3'd4 : starve_cnt + 3'd1;
    else                                    starve_cnt <= 3'd0;
  end
`else
  assign guard_take = 1'b0;
`endif

  // RAM strobes and write data for the single granted operation.
  always_comb begin
    ram_we        = 2'b00;
    ram_refill    = 1'b0;
    ram_load_over = 1'b0;
    ram_re        = lk_gnt;
    ram_raddr     = lk_gnt ? lk_index : raddr_q;
    ram_waddr     = rf_index;
    ram_din       = '0;
    if (rf_gnt) begin
      ram_we     = rf_way ? 2'b10 : 2'b01;
      ram_refill = 1'b1;
      // Tag goes to both slots; only the strobed way is written.
      ram_din    = {~rf_way, rf_way, rf_tag, ~rf_way, rf_tag};
    end else if (iv_gnt) begin
      ram_waddr     = iv_index;
      ram_we        = iv_way ? 2'b10 : 2'b01;
      ram_load_over = 1'b1;
      ram_din       = {(iv_touch ? ~iv_way : iv_way), iv_touch, {TAG_WIDTH{1'b0}},
                       iv_touch, {TAG_WIDTH{1'b0}}};
    end
  end

  // Sweep/run FSM with registered status outputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state           <= SWEEP;
      sweep_cnt       <= '0;
      init_done       <= 1'b0;
      ram_cache_reset <= 1'b0;
    end else if (flush_req) begin
      state           <= SWEEP;
      sweep_cnt       <= '0;
      init_done       <= 1'b0;
      ram_cache_reset <= 1'b0;
    end else begin
      case (state)
        SWEEP: begin
          if (sweep_cnt == CNT_MAX) begin
            state           <= RUN;
            sweep_cnt       <= '0;
            init_done       <= 1'b1;
            ram_cache_reset <= 1'b1;
          end else begin
            sweep_cnt <= sweep_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Read-valid pipe, last write address for the hazard check, held read address.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      lk_rvalid   <= 1'b0;
      wr_last_vld <= 1'b0;
      wr_last_idx <= '0;
      raddr_q     <= '0;
    end else begin
      lk_rvalid   <= lk_gnt;
      wr_last_vld <= rf_gnt | iv_gnt;
      wr_last_idx <= ram_waddr;
      raddr_q     <= ram_raddr;
    end
  end

endmodule

// File: tb/tb_tag_ram_sched.sv
// Bench for tag_ram_sched: directed scenarios plus a read-valid scoreboard.
module tb_tag_ram_sched;
  localparam int AW = 7;
  localparam int TW = 21;
  localparam int DW = 2*TW+3;

  logic          clk, resetn, flush_req, init_done;
  logic          lk_valid, lk_ready, lk_rvalid;
  logic [AW-1:0] lk_index;
  logic          rf_valid, rf_ready, rf_way;
  logic [AW-1:0] rf_index;
  logic [TW-1:0] rf_tag;
  logic          iv_valid, iv_ready, iv_way, iv_touch;
  logic [AW-1:0] iv_index;
  logic [AW-1:0] ram_raddr, ram_waddr;
  logic          ram_re, ram_refill, ram_load_over, ram_cache_reset;
  logic [1:0]    ram_we;
  logic [DW-1:0] ram_din;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int exp_q[$];

  tag_ram_sched #(.ADDR_WIDTH(AW), .TAG_WIDTH(TW)) dut (
    .clk(clk), .resetn(resetn), .flush_req(flush_req), .init_done(init_done),
    .lk_valid(lk_valid), .lk_ready(lk_ready), .lk_index(lk_index), .lk_rvalid(lk_rvalid),
    .rf_valid(rf_valid), .rf_ready(rf_ready), .rf_index(rf_index), .rf_way(rf_way), .rf_tag(rf_tag),
    .iv_valid(iv_valid), .iv_ready(iv_ready), .iv_index(iv_index), .iv_way(iv_way), .iv_touch(iv_touch),
    .ram_raddr(ram_raddr), .ram_waddr(ram_waddr), .ram_re(ram_re), .ram_we(ram_we),
    .ram_din(ram_din), .ram_refill(ram_refill), .ram_load_over(ram_load_over),
    .ram_cache_reset(ram_cache_reset)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: each expected lookup grant pushes the cycle its lk_rvalid must appear.
  always @(negedge clk) begin
    if (lk_rvalid) begin
      n_cmp++;
      if (exp_q.size() == 0 || exp_q[0] != cyc) begin
        n_err++;
        $display("FAIL rvalid_timing: got lk_rvalid at cycle %0d, expected cycle %0d",
                 cyc, (exp_q.size() == 0) ? -1 : exp_q[0]);
      end
      if (exp_q.size() != 0) void'(exp_q.pop_front());
    end else if (exp_q.size() != 0 && exp_q[0] <= cyc) begin
      n_cmp++;
      n_err++;
      $display("FAIL rvalid_missing: got lk_rvalid=0 at cycle %0d, expected 1", cyc);
      void'(exp_q.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  task automatic tick;
    @(negedge clk);
    #1;
  endtask

  task automatic test_reset;
    int n;
    tick;
    n_cmp++;
    if ({init_done, ram_cache_reset, lk_rvalid, ram_we, ram_re, ram_refill, ram_load_over,
         rf_ready, iv_ready, lk_ready} !== 11'd0) begin
      n_err++;
      $display("FAIL reset_outputs: got %b expected all zero",
               {init_done, ram_cache_reset, lk_rvalid, ram_we, ram_re, ram_refill, ram_load_over,
                rf_ready, iv_ready, lk_ready});
    end
    resetn = 1'b1;
    n = 0;
    while (!init_done && n < 300) begin
      n_cmp++;
      if ({ram_cache_reset, rf_ready, iv_ready, lk_ready, ram_we, ram_re} !== 7'd0) begin
        n_err++;
        $display("FAIL sweep_quiet: got %b expected 0 at sweep cycle %0d",
                 {ram_cache_reset, rf_ready, iv_ready, lk_ready, ram_we, ram_re}, n);
      end
      n++;
      tick;
    end
    n_cmp++;
    if (n != 128) begin n_err++; $display("FAIL sweep_len: got %0d expected 128", n); end
    n_cmp++;
    if (ram_cache_reset !== 1'b1) begin n_err++; $display("FAIL run_cache_reset: got %b expected 1", ram_cache_reset); end
    rf_valid = 1'b0; iv_valid = 1'b0; lk_valid = 1'b1; lk_index = 7'd0;
    #1;
    n_cmp++;
    if ({lk_ready, ram_re} !== 2'b11) begin n_err++; $display("FAIL first_lookup: got %b expected 11", {lk_ready, ram_re}); end
    exp_q.push_back(cyc + 1);
  endtask

  task automatic test_refill;
    tick;
    lk_valid = 1'b0; rf_valid = 1'b1; rf_index = 7'd5; rf_way = 1'b1; rf_tag = 21'h1ABCD;
    #1;
    n_cmp++;
    if ({rf_ready, ram_we, ram_refill, ram_load_over, ram_re} !== 6'b110100) begin
      n_err++; $display("FAIL refill_strobes: got %b expected 110100", {rf_ready, ram_we, ram_refill, ram_load_over, ram_re});
    end
    n_cmp++;
    if (ram_waddr !== 7'd5) begin n_err++; $display("FAIL refill_waddr: got %0d expected 5", ram_waddr); end
    n_cmp++;
    if ({ram_din[DW-1], ram_din[DW-2], ram_din[DW-3:TW+1]} !== {1'b0, 1'b1, 21'h1ABCD}) begin
      n_err++; $display("FAIL refill_din_w1: got %h expected lru0 v1=1 tag 1abcd", ram_din);
    end
    tick;
    rf_index = 7'd9; rf_way = 1'b0; rf_tag = 21'h00F0F;
    #1;
    n_cmp++;
    if ({ram_we, ram_din[DW-1], ram_din[TW], ram_din[TW-1:0]} !== {2'b01, 1'b1, 1'b1, 21'h00F0F}) begin
      n_err++; $display("FAIL refill_way0: got we=%b din=%h expected we=01 lru1 v0=1 tag f0f", ram_we, ram_din);
    end
    tick;
    rf_valid = 1'b0;
    #1;
    n_cmp++;
    if ({ram_we, ram_re, ram_refill, ram_load_over} !== 5'd0) begin
      n_err++; $display("FAIL idle_strobes: got %b expected 0", {ram_we, ram_re, ram_refill, ram_load_over});
    end
  endtask

  task automatic test_invalidate_touch;
    tick;
    iv_valid = 1'b1; iv_index = 7'd7; iv_way = 1'b1; iv_touch = 1'b0;
    #1;
    n_cmp++;
    if ({iv_ready, ram_we, ram_load_over, ram_refill, ram_waddr} !== {1'b1, 2'b10, 1'b1, 1'b0, 7'd7}) begin
      n_err++; $display("FAIL inval_strobes: got rdy=%b we=%b lo=%b rf=%b wa=%0d expected 1 10 1 0 7",
                        iv_ready, ram_we, ram_load_over, ram_refill, ram_waddr);
    end
    n_cmp++;
    if ({ram_din[DW-1], ram_din[DW-2]} !== 2'b10) begin
      n_err++; $display("FAIL inval_din: got lru/v1=%b expected 10", {ram_din[DW-1], ram_din[DW-2]});
    end
    tick;
    iv_index = 7'd3; iv_way = 1'b0; iv_touch = 1'b1;
    #1;
    n_cmp++;
    if ({ram_we, ram_load_over, ram_din[DW-1], ram_din[TW], ram_waddr} !== {2'b01, 1'b1, 1'b1, 1'b1, 7'd3}) begin
      n_err++; $display("FAIL touch: got we=%b lo=%b lru=%b v0=%b wa=%0d expected 01 1 1 1 3",
                        ram_we, ram_load_over, ram_din[DW-1], ram_din[TW], ram_waddr);
    end
    tick;
    iv_valid = 1'b0; lk_valid = 1'b1; lk_index = 7'd3;
    #1;
    n_cmp++;
    if ({lk_ready, ram_re} !== 2'b00) begin n_err++; $display("FAIL hazard_hold: got %b expected 00", {lk_ready, ram_re}); end
    tick;
    n_cmp++;
    if ({lk_ready, ram_re, ram_raddr} !== {2'b11, 7'd3}) begin
      n_err++; $display("FAIL hazard_release: got rdy/re=%b raddr=%0d expected 11 3", {lk_ready, ram_re}, ram_raddr);
    end
    exp_q.push_back(cyc + 1);
    tick;
    lk_valid = 1'b0; rf_valid = 1'b1; rf_index = 7'd12; rf_way = 1'b0; iv_valid = 1'b1; iv_index = 7'd13;
    #1;
    n_cmp++;
    if ({rf_ready, iv_ready, ram_refill, ram_waddr} !== {3'b101, 7'd12}) begin
      n_err++; $display("FAIL rf_over_iv: got %b wa=%0d expected 101 12", {rf_ready, iv_ready, ram_refill}, ram_waddr);
    end
    tick;
    rf_valid = 1'b0; iv_valid = 1'b0;
  endtask

  task automatic test_priority;
    tick;
    rf_valid = 1'b1; rf_index = 7'd10; rf_way = 1'b0; rf_tag = 21'h55; lk_valid = 1'b1; lk_index = 7'd20;
    #1;
    n_cmp++;
    if ({rf_ready, lk_ready, ram_re, ram_we} !== 5'b10001) begin
      n_err++; $display("FAIL rf_over_lk: got %b expected 10001", {rf_ready, lk_ready, ram_re, ram_we});
    end
    tick;
    rf_valid = 1'b0;
    #1;
    n_cmp++;
    if ({lk_ready, ram_re, ram_raddr} !== {2'b11, 7'd20}) begin
      n_err++; $display("FAIL lk_after_rf: got %b raddr=%0d expected 11 20", {lk_ready, ram_re}, ram_raddr);
    end
    exp_q.push_back(cyc + 1);
    tick;
    iv_valid = 1'b1; iv_index = 7'd30; iv_way = 1'b1; iv_touch = 1'b1; lk_index = 7'd21;
    #1;
    n_cmp++;
    if ({iv_ready, lk_ready, ram_re, ram_load_over} !== 4'b1001) begin
      n_err++; $display("FAIL iv_over_lk: got %b expected 1001", {iv_ready, lk_ready, ram_re, ram_load_over});
    end
    tick;
    iv_valid = 1'b0;
    #1;
    n_cmp++;
    if ({lk_ready, ram_raddr} !== {1'b1, 7'd21}) begin
      n_err++; $display("FAIL lk_after_iv: got rdy=%b raddr=%0d expected 1 21", lk_ready, ram_raddr);
    end
    exp_q.push_back(cyc + 1);
    tick;
    lk_valid = 1'b0; lk_index = 7'd99;
    #1;
    n_cmp++;
    if ({ram_re, ram_raddr} !== {1'b0, 7'd21}) begin
      n_err++; $display("FAIL raddr_hold: got re=%b raddr=%0d expected 0 21", ram_re, ram_raddr);
    end
  endtask

  task automatic test_flush;
    int n;
    tick;
    rf_valid = 1'b1; rf_index = 7'd2; flush_req = 1'b1;
    #1;
    n_cmp++;
    if ({rf_ready, ram_we, init_done} !== 4'b0001) begin
      n_err++; $display("FAIL flush_wins: got %b expected 0001", {rf_ready, ram_we, init_done});
    end
    tick;
    flush_req = 1'b0; rf_valid = 1'b0;
    #1;
    n_cmp++;
    if ({init_done, ram_cache_reset} !== 2'b00) begin
      n_err++; $display("FAIL flush_sweep: got %b expected 00", {init_done, ram_cache_reset});
    end
    for (int k = 0; k < 60; k++) begin
      n_cmp++;
      if ({init_done, ram_cache_reset} !== 2'b00) begin
        n_err++; $display("FAIL flush_pre: got %b expected 00 at %0d", {init_done, ram_cache_reset}, k);
      end
      tick;
    end
    flush_req = 1'b1;
    tick;
    flush_req = 1'b0;
    n = 0;
    while (!init_done && n < 300) begin
      n_cmp++;
      if (ram_cache_reset !== 1'b0) begin n_err++; $display("FAIL flush_restart: got %b expected 0", ram_cache_reset); end
      n++;
      tick;
    end
    n_cmp++;
    if (n != 128) begin n_err++; $display("FAIL flush_len: got %0d expected 128", n); end
  endtask

  task automatic test_reset_mid;
    int n;
    tick;
    lk_valid = 1'b1; lk_index = 7'd50;
    #1;
    n_cmp++;
    if (lk_ready !== 1'b1) begin n_err++; $display("FAIL mid_lk_ready: got %b expected 1", lk_ready); end
    resetn = 1'b0;
    tick;
    n_cmp++;
    if ({lk_rvalid, init_done, lk_ready} !== 3'b000) begin
      n_err++; $display("FAIL mid_reset: got %b expected 000", {lk_rvalid, init_done, lk_ready});
    end
    lk_valid = 1'b0;
    resetn = 1'b1;
    n = 0;
    while (!init_done && n < 300) begin n++; tick; end
    n_cmp++;
    if (n != 128) begin n_err++; $display("FAIL mid_sweep_len: got %0d expected 128", n); end
  endtask

  task automatic test_starve;
    logic exp_lk;
    tick;
    rf_valid = 1'b0; iv_valid = 1'b0; lk_valid = 1'b0;
    tick;
    rf_valid = 1'b1; lk_valid = 1'b1; lk_index = 7'd100;
    for (int i = 0; i < 15; i++) begin
      rf_index = 7'(40 + i);
      rf_way = 1'(i & 1);
      #1;
`ifdef TAG_SCHED_STARVE_GUARD_EN
      exp_lk = ((i % 5) == 4);
`else
      exp_lk = 1'b0;
`endif
      n_cmp++;
      if ({lk_ready, rf_ready} !== {exp_lk, ~exp_lk}) begin
        n_err++; $display("FAIL starve_%0d: got lk/rf ready=%b expected %b", i, {lk_ready, rf_ready}, {exp_lk, ~exp_lk});
      end
      if (exp_lk) exp_q.push_back(cyc + 1);
      tick;
    end
    rf_valid = 1'b0; lk_valid = 1'b0;
  endtask

  initial begin
    resetn = 1'b0; flush_req = 1'b0;
    lk_valid = 1'b1; lk_index = '0;
    rf_valid = 1'b1; rf_index = '0; rf_way = 1'b0; rf_tag = '0;
    iv_valid = 1'b1; iv_index = '0; iv_way = 1'b0; iv_touch = 1'b0;
    test_reset;
    test_refill;
    test_invalidate_touch;
    test_priority;
    test_flush;
    test_reset_mid;
    test_starve;
    tick; tick; tick;
    n_cmp++;
    if (exp_q.size() != 0) begin n_err++; $display("FAIL rvalid_pending: got %0d outstanding expected 0", exp_q.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
